ysyx_23060136_exu_div_iter: RTL and testbench
=============================================

Name: ysyx_23060136_exu_div_iter

Overview:
Parametrised iterative radix-2 restoring divider for the EXU, successor to the fixed 64-bit divider. It supports W-bit and half-width word (divw) operation, signed and unsigned modes, and RISC-V divide-by-zero and overflow semantics. Special cases resolve in a single cycle. The block sits behind the ALU issue path and returns results through a valid/ready output handshake with back-pressure; flush cancels an in-flight operation.

Parameters:
W, 64, datapath width in bits; must be even and at least 8.
HW, W/2, word-mode operand width used when divw=1 (derived, not overridable).
CW, $clog2(W+1), iteration counter width (derived).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dividend  in  W  dividend operand
divisor  in  W  divisor operand
div_valid  in  1  request valid
divw  in  1  1 = operate on low HW bits; results sign-extended from bit HW-1 to W
div_signed  in  1  1 = two's-complement operands
flush  in  1  cancel any in-flight or held operation
div_ready  out  1  block can accept a request (high only in IDLE)
div_out_valid  out  1  result valid
div_out_ready  in  1  consumer accepts result
quotient  out  W  quotient
remainder  out  W  remainder

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, div_out_valid=0, quotient=0, remainder=0, counter=0. div_ready=1 from the first cycle after reset.
- Accept occurs on the edge where div_valid && div_ready && !flush. At acceptance, latch the mode, the operand magnitudes (abs() when signed, after HW-truncation/extension in word mode), and the result signs: quotient negative = sign(dividend) XOR sign(divisor); remainder takes the dividend's sign.
- States:
  - IDLE: on accept, go to DONE if special, else CALC.
  - CALC: N iterations, one quotient bit per cycle, where N = W or HW. Each iteration shifts the partial remainder left, trial-subtracts the divisor, and sets the quotient bit if the result is non-negative. Go to FIX when the counter reaches N.
  - FIX: apply sign correction; apply sign-extension if divw; go to DONE.
  - DONE: div_out_valid=1; quotient and remainder are stable. Leave to IDLE on div_out_ready. Hold indefinitely while div_out_ready=0.
- Latency for an accept at edge t:
  - normal op: div_out_valid rises in cycle t+N+2 (66 cycles for W=64, 34 for divw);
  - special case: div_out_valid rises in cycle t+1.
- Special cases, evaluated on the effective (word-truncated) operands:
  - divisor==0: quotient = all ones (sign-extended in word mode), remainder = dividend (sign-extended in word mode). Applies to both signed and unsigned.
  - signed, dividend = most-negative, divisor = -1: quotient = dividend, remainder = 0.
- Sign correction uses two's complement negation of the unsigned result. The partial remainder is W+1 bits wide internally.
- Flush has priority over everything. It returns the FSM to IDLE on the next edge with div_out_valid=0; no result is produced. If flush and div_valid are both high in the same cycle, the request is not accepted.
- div_ready=0 in CALC, FIX and DONE. The block accepts no new request in the DONE→IDLE handoff cycle.
- quotient and remainder are registered; their values are undefined-but-stable whenever div_out_valid=0.
- Reset mid-operation: identical to power-on reset; no result emerges.

Decomposition:
- Shared package ysyx_23060136_div_pkg holds:
  - state enum div_state_e {IDLE, CALC, FIX, DONE};
  - a function for the special-case result;
  - a function for sign-extension from HW.
- One natural sub-module: ysyx_23060136_div_step. It is a combinational single iteration taking partial remainder, divisor and dividend bit, and producing the next partial remainder and quotient bit. This allows later radix-4 unrolling by instancing it twice.

Test Plan:
- Unsigned, W=64: 100/7 → quotient=14, remainder=2; div_out_valid exactly 66 cycles after accept; div_ready low throughout.
- Signed: -7/2 → quotient=0xFFFF_FFFF_FFFF_FFFD, remainder=0xFFFF_FFFF_FFFF_FFFF. Signed 7/-2 → quotient=-3, remainder=1.
- Divide by zero: 5/0 unsigned → quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5, valid at t+1. Signed overflow: 0x8000_0000_0000_0000 / -1 → quotient=0x8000_0000_0000_0000, remainder=0, valid at t+1.
- Word mode:
  - divw signed, dividend 0x1_8000_0000, divisor 0xFFFF_FFFF → quotient=0xFFFF_FFFF_8000_0000, remainder=0 (overflow path);
  - divw unsigned 0xFFFF_FFFF/2 → quotient=0x7FFF_FFFF, remainder=1, latency 34.
- Back-pressure: hold div_out_ready=0 for 10 cycles after a result → outputs stable, div_ready=0; one cycle of ready → IDLE next edge.
- Flush: assert flush on cycle 20 of CALC → div_out_valid never rises, div_ready=1 next cycle. An immediate new request 9/3 then returns quotient=3, remainder=0. Flush and div_valid in the same cycle → no accept.

Source files
------------

// File: rtl/ysyx_23060136_div_pkg.sv
// Shared types and helpers for the iterative divider.
// Helpers work on a wide container so any even W up to DIV_MAXW fits.
package ysyx_23060136_div_pkg;

  localparam int DIV_MAXW = 128;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  typedef struct packed {
    logic                hit;
    logic [DIV_MAXW-1:0] q;
    logic [DIV_MAXW-1:0] r;
  } div_special_t;

  function automatic logic [DIV_MAXW-1:0] div_sext(
    input logic [DIV_MAXW-1:0] x,
    input int                  n
  );
    logic [DIV_MAXW-1:0] m;
    logic [DIV_MAXW-1:0] sb;
    m  = '1;
    m  = m << n;
    sb = DIV_MAXW'(1) << (n - 1);
    return (|(x & sb)) ? (x | m) : (x & ~m);
  endfunction

  // Divide-by-zero and signed overflow on the low n bits of a and b.
  function automatic div_special_t div_special(
    input logic [DIV_MAXW-1:0] a,
    input logic [DIV_MAXW-1:0] b,
    input logic                sgn,
    input int                  n
  );
    logic [DIV_MAXW-1:0] mask;
    logic [DIV_MAXW-1:0] an;
    logic [DIV_MAXW-1:0] bn;
    logic [DIV_MAXW-1:0] mn;
    div_special_t        res;
    mask = '1;
    mask = ~(mask << n);
    an   = a & mask;
    bn   = b & mask;
    mn   = DIV_MAXW'(1) << (n - 1);
    res  = '0;
    if (bn == '0) begin
      res.hit = 1'b1;
      res.q   = '1;
      res.r   = div_sext(an, n);
    end else if (sgn && (an == mn) && (bn == mask)) begin
      res.hit = 1'b1;
      res.q   = div_sext(an, n);
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_23060136_div_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if non-negative.
module ysyx_23060136_div_step
  import ysyx_23060136_div_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] dvs_i,
  input  logic         bit_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W+1:0] sh;
  logic [W+1:0] diff;

  always_comb begin
    sh    = {rem_i, bit_i};
    diff  = sh - {2'b00, dvs_i};
    q_o   = ~diff[W+1];
    rem_o = q_o ? diff[W:0] : sh[W:0];
  end

endmodule

// File: rtl/ysyx_23060136_exu_div_iter.sv
// Iterative radix-2 restoring divider, W-bit and half-width word mode,
// signed/unsigned, single-cycle special cases, valid/ready result port.
module ysyx_23060136_exu_div_iter
  import ysyx_23060136_div_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         div_valid,
  input  logic         divw,
  input  logic         div_signed,
  input  logic         flush,
  output logic         div_ready,
  output logic         div_out_valid,
  input  logic         div_out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int HW = W / 2;
  localparam int CW = $clog2(W + 1);

  div_state_e   state_q, state_d;
  logic         valid_q, valid_d;
  logic [W-1:0] quotient_q, quotient_d;
  logic [W-1:0] remainder_q, remainder_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]   rem_q, rem_d;
  logic [W-1:0] dvd_q, dvd_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic [W-1:0] quo_q, quo_d;
  logic         word_q, word_d;
  logic         negq_q, negq_d;
  logic         negr_q, negr_d;

  logic [W-1:0] a_eff, b_eff, a_mag, b_mag;
  logic         sa, sb;
  div_special_t sp;
  logic [W:0]   rem_step;
  logic         q_step;
  logic [W-1:0] q_fix, r_fix;
  logic [DIV_MAXW-1:0] q_ext, r_ext;
  logic [CW-1:0] n_lim;
  logic         unused_ext;

  ysyx_23060136_div_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (dvd_q[W-1]),
    .rem_o (rem_step),
    .q_o   (q_step)
  );

  always_comb begin
    a_eff = divw ? {{HW{div_signed & dividend[HW-1]}}, dividend[HW-1:0]}
                 : dividend;
    b_eff = divw ? {{HW{div_signed & divisor[HW-1]}}, divisor[HW-1:0]}
                 : divisor;
    sa    = div_signed & a_eff[W-1];
    sb    = div_signed & b_eff[W-1];
    a_mag = sa ? -a_eff : a_eff;
    b_mag = sb ? -b_eff : b_eff;
    sp    = div_special(DIV_MAXW'(a_eff), DIV_MAXW'(b_eff),
                        div_signed, divw ? HW : W);
    q_fix = negq_q ? -quo_q : quo_q;
    r_fix = negr_q ? -rem_q[W-1:0] : rem_q[W-1:0];
    q_ext = div_sext(DIV_MAXW'(q_fix), HW);
    r_ext = div_sext(DIV_MAXW'(r_fix), HW);
    n_lim = word_q ? CW'(HW) : CW'(W);
  end

  assign unused_ext = ^{sp.q[DIV_MAXW-1:W], sp.r[DIV_MAXW-1:W],
                        q_ext[DIV_MAXW-1:W], r_ext[DIV_MAXW-1:W]};

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    word_d      = word_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (div_valid) begin
            word_d = divw;
            negq_d = sa ^ sb;
            negr_d = sa;
            if (sp.hit) begin
              quotient_d  = sp.q[W-1:0];
              remainder_d = sp.r[W-1:0];
              valid_d     = 1'b1;
              state_d     = DONE;
            end else begin
              rem_d   = '0;
              quo_d   = '0;
              cnt_d   = '0;
              dvs_d   = b_mag;
              // word operands are left-aligned so bits leave MSB-first
              dvd_d   = divw ? (a_mag << HW) : a_mag;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = rem_step;
          quo_d = {quo_q[W-2:0], q_step};
          dvd_d = dvd_q << 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == n_lim) begin
            state_d = FIX;
          end
        end
        FIX: begin
          quotient_d  = word_q ? q_ext[W-1:0] : q_fix;
          remainder_d = word_q ? r_ext[W-1:0] : r_fix;
          valid_d     = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (div_out_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      word_q      <= 1'b0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      word_q      <= word_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
    end
  end

  assign div_ready     = (state_q == IDLE);
  assign div_out_valid = valid_q;
  assign quotient      = quotient_q;
  assign remainder     = remainder_q;

endmodule

// File: tb/tb_ysyx_23060136_exu_div_iter.sv
// Scoreboard bench for the iterative divider: directed vectors,
// expected results queued at issue and checked by a monitor.
module tb_ysyx_23060136_exu_div_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        div_valid = 1'b0;
  logic        divw = 1'b0;
  logic        div_signed = 1'b0;
  logic        flush = 1'b0;
  logic        div_ready;
  logic        div_out_valid;
  logic        div_out_ready = 1'b1;
  logic [63:0] quotient;
  logic [63:0] remainder;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_v = 1'b0;

  ysyx_23060136_exu_div_iter #(.W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .dividend      (dividend),
    .divisor       (divisor),
    .div_valid     (div_valid),
    .divw          (divw),
    .div_signed    (div_signed),
    .flush         (flush),
    .div_ready     (div_ready),
    .div_out_valid (div_out_valid),
    .div_out_ready (div_out_ready),
    .quotient      (quotient),
    .remainder     (remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (div_out_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_valid: got q=%h r=%h expected none",
                 quotient, remainder);
      end else begin
        chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
      end
    end
    if (div_out_valid && div_out_ready && exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("quotient", quotient, e.q);
      chk("remainder", remainder, e.r);
    end
    prev_v = div_out_valid;
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic w, input logic s,
                       input logic [63:0] eq, input logic [63:0] er,
                       input int lat, input bit push);
    @(posedge clk);
    #1;
    chk("ready_pre", 64'(div_ready), 64'd1);
    dividend   = a;
    divisor    = b;
    divw       = w;
    div_signed = s;
    div_valid  = 1'b1;
    if (push) exp_q.push_back('{q: eq, r: er, lat: lat, acc: cyc});
    @(posedge clk);
    #1;
    div_valid = 1'b0;
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b,
                     input logic w, input logic s,
                     input logic [63:0] eq, input logic [63:0] er,
                     input int lat, input bit hold);
    int n;
    bit bad;
    bit stable;
    div_out_ready = !hold;
    issue(a, b, w, s, eq, er, lat, 1'b1);
    n = 0;
    bad = 1'b0;
    @(negedge clk);
    while (!div_out_valid && n < 200) begin
      if (div_ready) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("timeout", 64'(div_out_valid), 64'd1);
    chk("ready_low", 64'(bad | div_ready), 64'd0);
    if (hold) begin
      stable = 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (quotient !== eq || remainder !== er ||
            !div_out_valid || div_ready) stable = 1'b0;
      end
      chk("bp_stable", 64'(stable), 64'd1);
      @(posedge clk);
      #1;
      div_out_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("idle_after", 64'({div_out_valid, div_ready}), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(div_out_valid), 64'd0);
    chk("rst_ready", 64'(div_ready), 64'd1);
    chk("rst_q", quotient, 64'd0);
    chk("rst_r", remainder, 64'd0);

    run(64'd100, 64'd7, 0, 0, 64'd14, 64'd2, 66, 0);
    run(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 1,
        64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1,
        64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66, 0);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 0, 0,
        64'hFFFF_FFFF, 64'hFFFF_FFFF, 66, 0);
    run(64'd5, 64'd0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, 0);
    run(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1,
        64'h8000_0000_0000_0000, 64'd0, 1, 0);
    run(64'h1_8000_0000, 64'hFFFF_FFFF, 1, 1,
        64'hFFFF_FFFF_8000_0000, 64'd0, 1, 0);
    run(64'hFFFF_FFFF, 64'd2, 1, 0, 64'h7FFF_FFFF, 64'd1, 34, 0);
    run(64'h1234_5678_FFFF_FF9C, 64'd7, 1, 1,
        64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
    run(64'h8000_0005, 64'h5_0000_0000, 1, 0,
        64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1, 0);
    run(64'd1000, 64'd10, 0, 0, 64'd100, 64'd0, 66, 1);

    issue(64'd1000, 64'd3, 0, 0, 64'd0, 64'd0, 0, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", 64'({div_out_valid, div_ready}), 64'd1);
    run(64'd9, 64'd3, 0, 0, 64'd3, 64'd0, 66, 0);

    @(posedge clk);
    #1;
    dividend  = 64'd9;
    divisor   = 64'd3;
    divw      = 1'b0;
    div_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    chk("flush_noacc", 64'({div_out_valid, div_ready}), 64'd1);
    repeat (80) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
